add32_block_accum: RTL and testbench



---
 rtl/add_pkg.sv | 35 +++
 rtl/add32_block_accum_if.sv | 33 +++
 rtl/acc_adder.sv | 34 +++
 rtl/add32_block_accum.sv | 160 ++++++++++++++++
 tb/tb_add32_block_accum.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/add_pkg.sv
// ---------------------------------------------------------------------------
// add_pkg
// Shared definitions for the block accumulator that sits after the 32-bit
// adder: FSM state encoding, default datapath widths, the counter-width
// helper and the single-bit full-adder cell used to build ripple adders.
// ---------------------------------------------------------------------------
package add_pkg;

   // Default widths: input matches the upstream adder result, the
   // accumulator carries 8 guard bits for block totals.
   localparam int ADD_DATA_W = 32;
   localparam int ADD_ACC_W  = 40;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Counter must hold the values 0..count inclusive.
   function automatic int cnt_width(input int count);
      return $clog2(count + 1);
   endfunction

   // Full-adder cell, returned as {carry_out, sum}. Same cell the upstream
   // adder ripples, so both arithmetic paths share one style.
   function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
      logic s;
      logic co;
      s  = a ^ b ^ ci;
      co = (a & b) | (ci & (a ^ b));
      return {co, s};
   endfunction

endpackage

// File: rtl/add32_block_accum_if.sv
// ---------------------------------------------------------------------------
// add32_block_accum_if
// Valid/ready bundle for the block accumulator.
//   in_valid / in_ready / in_data    : sample stream from the adder
//   out_valid / out_ready            : block-result handshake
//   out_sum / out_ovf                : block total and sticky overflow
// Modports: master = upstream producer / downstream consumer side,
//           slave  = the accumulator block itself.
// ---------------------------------------------------------------------------
interface add32_block_accum_if
   import add_pkg::*;
#(
   parameter int DATA_W = ADD_DATA_W,
   parameter int ACC_W  = ADD_ACC_W
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_sum;
   logic              out_ovf;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_sum, out_ovf
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_sum, out_ovf
   );
endinterface

// File: rtl/acc_adder.sv
// ---------------------------------------------------------------------------
// acc_adder
// W-bit unsigned ripple adder with carry-in tied low.
//   a, b  : operands
//   sum   : a + b modulo 2^W
//   carry : carry out of bit W-1
// ---------------------------------------------------------------------------
module acc_adder
   import add_pkg::*;
#(
   parameter int W = ADD_ACC_W
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         carry
);

   // Ripple the full-adder cell from bit 0 upward.
   always_comb begin : ripple
      logic       c_s;
      logic [1:0] fa_s;
      sum  = {W{1'b0}};
      c_s  = 1'b0;
      fa_s = 2'b00;
      for (int i = 0; i < W; i++) begin
         fa_s   = full_add(a[i], b[i], c_s);
         sum[i] = fa_s[0];
         c_s    = fa_s[1];
      end
      carry = c_s;
   end

endmodule

// File: rtl/add32_block_accum.sv
// ---------------------------------------------------------------------------
// add32_block_accum
// Accumulates COUNT accepted input sums per block into an ACC_W-bit total
// and presents the total with a sticky overflow flag.
//   clk    : single clock, rising edge
//   reset  : asynchronous, active-high, clears all state
//   clear  : synchronous abort of the current block (drops pending result)
//   bus    : slave side of the valid/ready bundle (input stream + result)
//   busy   : at least one sample of the current block has been accepted
// ---------------------------------------------------------------------------
module add32_block_accum
   import add_pkg::*;
#(
   parameter int DATA_W = ADD_DATA_W,
   parameter int ACC_W  = ADD_ACC_W,
   parameter int COUNT  = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   add32_block_accum_if.slave   bus,
   output logic                 busy
);

   localparam int               CNT_W    = cnt_width(COUNT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

   state_t           state;
   state_t           state_nxt;
   logic             accept;
   logic [ACC_W-1:0] ext;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] add_sum;
   logic             add_carry;
   logic [CNT_W-1:0] cnt;
   logic             ovf;

   // in_ready is a pure state decode, so it is used directly here.
   assign accept = bus.in_valid && (state != DONE);
   assign ext    = ACC_W'(bus.in_data);

   acc_adder #(.W(ACC_W)) u_acc_adder (
      .a     (acc),
      .b     (ext),
      .sum   (add_sum),
      .carry (add_carry)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next-state logic; clear overrides every transition.
   always_comb begin
      state_nxt = state;
      if (clear) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state_nxt = (COUNT == 1) ? DONE : ACCUM;
               end else begin
                  state_nxt = IDLE;
               end
            end
            ACCUM: begin
               if (accept && (cnt == CNT_LAST)) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = ACCUM;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state_nxt = IDLE;
               end else begin
                  state_nxt = DONE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // FSM output decode; result fields come straight from registers.
   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      busy          = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
         end
         ACCUM: begin
            bus.in_ready = 1'b1;
            busy         = 1'b1;
         end
         DONE: begin
            bus.out_valid = 1'b1;
         end
         default: begin
            bus.in_ready  = 1'b0;
            bus.out_valid = 1'b0;
            busy          = 1'b0;
         end
      endcase
      bus.out_sum = acc;
      bus.out_ovf = ovf;
   end

   // Accumulator, sample counter and sticky overflow.
   // The first accept of a block loads acc rather than adding, which also
   // clears the previous block's overflow. acc is left stale after the
   // result is taken so out_sum needs no extra hold register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc <= {ACC_W{1'b0}};
         cnt <= {CNT_W{1'b0}};
         ovf <= 1'b0;
      end else if (clear) begin
         acc <= {ACC_W{1'b0}};
         cnt <= {CNT_W{1'b0}};
         ovf <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  acc <= ext;
                  cnt <= CNT_W'(1);
                  ovf <= 1'b0;
               end
            end
            ACCUM: begin
               if (accept) begin
                  acc <= add_sum;
                  cnt <= cnt + CNT_W'(1);
                  ovf <= ovf | add_carry;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  cnt <= {CNT_W{1'b0}};
               end
            end
            default: begin
               acc <= {ACC_W{1'b0}};
               cnt <= {CNT_W{1'b0}};
               ovf <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_add32_block_accum.sv
// ---------------------------------------------------------------------------
// tb_add32_block_accum
// Directed bench for add32_block_accum: a default 40-bit instance and a
// 33-bit instance for the overflow case, sharing clock, reset and clear.
// ---------------------------------------------------------------------------
module tb_add32_block_accum;

   logic clk = 1'b0;
   logic reset;
   logic clear;
   logic busy40;
   logic busy33;
   int   checks   = 0;
   int   failures = 0;

   add32_block_accum_if #(.DATA_W(32), .ACC_W(40)) b40 ();
   add32_block_accum_if #(.DATA_W(32), .ACC_W(33)) b33 ();

   add32_block_accum #(.DATA_W(32), .ACC_W(40), .COUNT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .bus   (b40),
      .busy  (busy40)
   );

   add32_block_accum #(.DATA_W(32), .ACC_W(33), .COUNT(4)) dut33 (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .bus   (b33),
      .busy  (busy33)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic put40(input logic [31:0] d);
      b40.in_valid = 1'b1;
      b40.in_data  = d;
      tick();
   endtask

   task automatic put33(input logic [31:0] d);
      b33.in_valid = 1'b1;
      b33.in_data  = d;
      tick();
   endtask

   initial begin
      logic       pat_v [7];
      logic [31:0] pat_d [7];
      pat_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      pat_d = '{32'd10, 32'd0, 32'd0, 32'd20, 32'd0, 32'd30, 32'd40};

      reset         = 1'b1;
      clear         = 1'b0;
      b40.in_valid  = 1'b0;
      b40.in_data   = 32'd0;
      b40.out_ready = 1'b1;
      b33.in_valid  = 1'b0;
      b33.in_data   = 32'd0;
      b33.out_ready = 1'b1;
      #1;

      // Reset state
      chk("rst_out_valid", 64'(b40.out_valid), 64'd0);
      chk("rst_busy",      64'(busy40),        64'd0);
      chk("rst_in_ready",  64'(b40.in_ready),  64'd1);
      chk("rst_out_sum",   64'(b40.out_sum),   64'd0);
      chk("rst_out_ovf",   64'(b40.out_ovf),   64'd0);
      // No transfer while reset is held
      b40.in_valid = 1'b1;
      b40.in_data  = 32'd99;
      tick();
      tick();
      chk("rst_no_accept", 64'(busy40), 64'd0);
      b40.in_valid = 1'b0;
      reset = 1'b0;
      tick();

      // 1,2,3,4 back to back
      put40(32'd1);
      chk("t1_busy_first", 64'(busy40), 64'd1);
      chk("t1_no_valid",   64'(b40.out_valid), 64'd0);
      put40(32'd2);
      put40(32'd3);
      put40(32'd4);
      b40.in_valid = 1'b0;
      chk("t1_out_valid", 64'(b40.out_valid), 64'd1);
      chk("t1_in_ready",  64'(b40.in_ready),  64'd0);
      chk("t1_busy_done", 64'(busy40),        64'd0);
      chk("t1_out_sum",   64'(b40.out_sum),   64'd10);
      chk("t1_out_ovf",   64'(b40.out_ovf),   64'd0);
      tick();
      chk("t1_valid_drop",  64'(b40.out_valid), 64'd0);
      chk("t1_ready_back",  64'(b40.in_ready),  64'd1);

      // 33-bit accumulator overflow, then a clean block
      put33(32'hFFFF_FFFF);
      put33(32'hFFFF_FFFF);
      put33(32'hFFFF_FFFF);
      put33(32'hFFFF_FFFF);
      b33.in_valid = 1'b0;
      chk("t2_out_valid", 64'(b33.out_valid), 64'd1);
      chk("t2_out_sum",   64'(b33.out_sum),   64'h1_FFFF_FFFC);
      chk("t2_out_ovf",   64'(b33.out_ovf),   64'd1);
      tick();
      put33(32'd1);
      put33(32'd1);
      put33(32'd1);
      put33(32'd1);
      b33.in_valid = 1'b0;
      chk("t2b_out_sum", 64'(b33.out_sum), 64'd4);
      chk("t2b_out_ovf", 64'(b33.out_ovf), 64'd0);
      tick();

      // Backpressure on the result
      b40.out_ready = 1'b0;
      put40(32'd7);
      put40(32'd7);
      put40(32'd7);
      put40(32'd7);
      b40.in_valid = 1'b1;
      b40.in_data  = 32'd3;
      for (int i = 0; i < 5; i++) begin
         chk("t3_hold_valid", 64'(b40.out_valid), 64'd1);
         chk("t3_hold_sum",   64'(b40.out_sum),   64'd28);
         chk("t3_hold_ready", 64'(b40.in_ready),  64'd0);
         tick();
      end
      b40.out_ready = 1'b1;
      tick();
      chk("t3_released", 64'(b40.out_valid), 64'd0);
      tick();
      chk("t3_held_taken", 64'(busy40), 64'd1);
      put40(32'd1);
      put40(32'd1);
      put40(32'd1);
      b40.in_valid = 1'b0;
      chk("t3_next_valid", 64'(b40.out_valid), 64'd1);
      chk("t3_next_sum",   64'(b40.out_sum),   64'd6);
      tick();

      // Bubbles in the input stream
      for (int i = 0; i < 7; i++) begin
         b40.in_valid = pat_v[i];
         b40.in_data  = pat_d[i];
         tick();
         if (i < 6) begin
            chk("t4_busy", 64'(busy40), 64'd1);
         end
      end
      b40.in_valid = 1'b0;
      chk("t4_out_valid", 64'(b40.out_valid), 64'd1);
      chk("t4_busy_done", 64'(busy40),        64'd0);
      chk("t4_out_sum",   64'(b40.out_sum),   64'd100);
      tick();

      // clear mid-block discards accepted samples and the concurrent input
      put40(32'd9);
      put40(32'd9);
      clear        = 1'b1;
      b40.in_valid = 1'b1;
      b40.in_data  = 32'd50;
      tick();
      clear = 1'b0;
      chk("t5_clr_busy",  64'(busy40),       64'd0);
      chk("t5_clr_ready", 64'(b40.in_ready), 64'd1);
      chk("t5_clr_sum",   64'(b40.out_sum),  64'd0);
      put40(32'd5);
      put40(32'd5);
      put40(32'd5);
      put40(32'd5);
      b40.in_valid = 1'b0;
      chk("t5_out_valid", 64'(b40.out_valid), 64'd1);
      chk("t5_out_sum",   64'(b40.out_sum),   64'd20);
      // clear in DONE drops the result even with out_ready high
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("t5_drop_valid", 64'(b40.out_valid), 64'd0);
      chk("t5_drop_sum",   64'(b40.out_sum),   64'd0);

      // Asynchronous reset while a result is pending
      b40.out_ready = 1'b0;
      put40(32'd1);
      put40(32'd1);
      put40(32'd1);
      put40(32'd1);
      b40.in_valid = 1'b0;
      chk("t6_pre_valid", 64'(b40.out_valid), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("t6_async_valid", 64'(b40.out_valid), 64'd0);
      chk("t6_async_busy",  64'(busy40),        64'd0);
      chk("t6_async_sum",   64'(b40.out_sum),   64'd0);
      chk("t6_async_ready", 64'(b40.in_ready),  64'd1);
      #2;
      reset = 1'b0;
      b40.out_ready = 1'b1;
      tick();
      put40(32'd2);
      put40(32'd2);
      put40(32'd2);
      put40(32'd2);
      b40.in_valid = 1'b0;
      chk("t6_out_valid", 64'(b40.out_valid), 64'd1);
      chk("t6_out_sum",   64'(b40.out_sum),   64'd8);
      tick();
      chk("t6_done_taken", 64'(b40.out_valid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
